serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial full subtractor: computes diff = a - b - bin over WIDTH bits, LSB first.
//   Uses one full-subtractor cell and a borrow flip-flop, one bit per clock.
//   Counterpart to the combinational full_adder; used where area matters more than latency.
//   Start/done handshake; result is held until the next accepted start.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range is >=1.
// PORTS
//   clk    in   1      single clock; all state updates on the rising edge
//   rst_n  in   1      reset, synchronous, active-low
//   start  in   1      request; sampled only in IDLE or DONE
//   a      in   WIDTH  minuend, captured on an accepted start
//   b      in   WIDTH  subtrahend, captured on an accepted start
//   bin    in   1      borrow-in, captured on an accepted start
//   busy   out  1      high while in SHIFT
//   done   out  1      one-cycle pulse; diff and bout are valid from this cycle on
//   diff   out  WIDTH  difference
//   bout   out  1      borrow-out (1 when a < b + bin, unsigned)
//   ovf    out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge):
//     - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
//     - Internal shift registers, borrow flip-flop and bit counter clear.
//     - Mid-operation reset aborts the operation; the partial result is discarded.
//   - FSM states: IDLE, SHIFT, DONE.
//     - IDLE: start=1 -> capture a, b, bin; counter=0; go to SHIFT. Otherwise stay.
//     - SHIFT: busy=1. Each cycle processes bit i = a_sr[0], b_sr[0] with borrow br:
//         d      = a_sr[0] ^ b_sr[0] ^ br
//         br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)
//       Shift a_sr and b_sr right. Shift d into the MSB of the result register.
//       Counter increments. After the WIDTH-th bit, go to DONE.
//     - DONE: lasts exactly one cycle with done=1. diff = result register; bout = final borrow.
//       start=1 here is accepted exactly as in IDLE (back-to-back ops); else go to IDLE.
//   - Latency: start sampled at edge 0; SHIFT occupies edges 1..WIDTH; done=1 in the cycle after edge WIDTH.
//     Throughput is one operation per WIDTH+1 cycles.
//   - start is ignored while busy=1. Changes on a, b, bin after capture have no effect.
//   - diff and bout update only when entering DONE. They hold through IDLE and the next SHIFT.
//   - Arithmetic: modulo 2^WIDTH. {bout,diff} equals a - b - bin as an unsigned WIDTH+1 borrow result.
//   - WIDTH=1 reduces to the 1-bit full-subtractor truth table; latency is 2 cycles.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     - Port ovf exists.
//     - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
//     - Updates with diff; reset 0.
//   SERIAL_SUB_OVF_EN undefined:
//     - Port ovf and its logic are absent.
//     - All other behaviour is identical.
// TESTING
//   1. WIDTH=8: a=0x05, b=0x03, bin=0, start 1 cycle -> busy for 8 cycles;
//      done pulses in cycle 9; diff=0x02, bout=0.
//   2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
//      a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
//   3. Hold start=1 through the op, changing a/b during SHIFT -> result reflects the captured values only.
//      Retrigger taken in the DONE cycle -> second done exactly 9 cycles after the first.
//   4. rst_n=0 at SHIFT cycle 4 -> next cycle busy=0, done=0, diff=0, bout=0.
//      No done pulse follows.
//   5. With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1.
//      a=0x7F, b=0xFF -> diff=0x80, ovf=1. a=0x10, b=0x01 -> ovf=0.
//   6. WIDTH=1: all 8 (a,b,bin) combos -> (diff,bout) = 000:00 001:11 010:11 011:01 100:10 101:00 110:00 111:11.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial full subtractor. Computes diff = a - b - bin over
//               WIDTH bits, LSB first, one bit per clock, using a single
//               full-subtractor cell and a borrow flip-flop.
//               Start/done handshake; the result holds until the next
//               accepted start completes.
// Parameters  : WIDTH  operand/result width in bits (>= 1), default 8
// Ports       : clk    clock, rising edge
//               rst_n  synchronous active-low reset
//               start  request, sampled only in IDLE or DONE
//               a, b   minuend / subtrahend, captured on an accepted start
//               bin    borrow-in, captured on an accepted start
//               busy   high while bits are being processed (SHIFT)
//               done   one-cycle pulse; diff/bout valid from this cycle on
//               diff   difference (modulo 2^WIDTH)
//               bout   borrow-out (1 when a < b + bin, unsigned)
//               ovf    signed overflow (only with SERIAL_SUB_OVF_EN)
// Options     : `define SERIAL_SUB_OVF_EN to add the ovf port and its logic.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter needs at least one bit even when WIDTH == 1.
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // --------------------------------------------------------------------------
  // Full-subtractor cell on the current LSBs
  // --------------------------------------------------------------------------
  assign d       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  // New bit enters at the MSB; the oldest bit falls out of the bottom.
  // Written as a shift of the concatenation so WIDTH == 1 needs no special case.
  assign res_nxt = WIDTH'({d, res_sr} >> 1);

  assign last_bit = (cnt == LAST);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start here chains directly into the next operation.
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shifters, borrow, counter, result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      br     <= br_nxt;
      cnt    <= cnt + CW'(1);
      // Published results change only on the transition into DONE.
      if (last_bit) begin
        diff <= res_nxt;
        bout <= br_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // --------------------------------------------------------------------------
  // Signed overflow: operand signs differ and the result sign differs from a.
  // The operand sign bits are kept aside because the shifters consume them.
  // --------------------------------------------------------------------------
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == SHIFT) && last_bit) begin
      ovf <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8 and
//               WIDTH=1 instances). Expected values come from plain
//               (WIDTH+1)-bit arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         bin1;
  logic         busy1;
  logic         done1;
  logic [0:0]   diff1;
  logic         bout1;

`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         ovf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance edge by edge until done is seen (bounded). Operands are scrambled
  // every cycle so that only the captured values can influence the result.
  // edges counts clock edges from the start-sampling edge up to the one after
  // which done is visible; -1 when the bound expires.
  task automatic wait_done(input bit hold, output int edges, output int busy_cycles);
    bit got;
    got         = 1'b0;
    edges       = -1;
    busy_cycles = 0;
    for (int e = 1; e <= 4 * W && !got; e++) begin
      @(posedge clk);
      #1;
      start = hold;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      if (done) begin
        got   = 1'b1;
        edges = e;
      end else if (busy) begin
        busy_cycles++;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta,
                              input logic [W-1:0] tb, input logic tbin);
    logic [W:0] ref_v;
    ref_v = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    check({tag, " diff"}, 32'(diff), 32'(ref_v[W-1:0]));
    check({tag, " bout"}, 32'(bout), 32'(ref_v[W]));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf),
          32'((ta[W-1] != tb[W-1]) && (ref_v[W-1] != ta[W-1])));
`endif
  endtask

  // One complete operation with start pulsed for a single cycle.
  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tbin);
    int edges;
    int bc;
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    wait_done(1'b0, edges, bc);
    check({tag, " latency"}, 32'(edges), 32'(W + 1));
    check({tag, " busy cycles"}, 32'(bc), 32'(W));
    check_result(tag, ta, tb, tbin);
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [1:0]   r1;
    int           edges;
    int           bc;
    int           done_seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    bin1   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, including borrow wrap cases
    run_op("d05m03", 8'h05, 8'h03, 1'b0);
    run_op("d03m05", 8'h03, 8'h05, 1'b0);
    run_op("d00m00b", 8'h00, 8'h00, 1'b1);
    run_op("d80m01", 8'h80, 8'h01, 1'b0);
    run_op("d7Fm FF", 8'h7F, 8'hFF, 1'b0);
    run_op("d10m01", 8'h10, 8'h01, 1'b0);
    run_op("dFFmFFb", 8'hFF, 8'hFF, 1'b1);

    // Result must hold through idle cycles
    repeat (3) @(posedge clk);
    #1;
    check("hold diff in idle", 32'(diff), 32'h00 - 32'h01 & 32'hFF);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rbin);
    end

    // Start held high through the op; retrigger taken in the DONE cycle
    a     = 8'hC4;
    b     = 8'h39;
    bin   = 1'b1;
    start = 1'b1;
    wait_done(1'b1, edges, bc);
    check("held op1 latency", 32'(edges), 32'(W + 1));
    check_result("held op1", 8'hC4, 8'h39, 1'b1);
    a   = 8'h21;
    b   = 8'h5A;
    bin = 1'b0;
    wait_done(1'b1, edges, bc);
    start = 1'b0;
    check("retrigger spacing", 32'(edges), 32'(W + 1));
    check_result("held op2", 8'h21, 8'h5A, 1'b0);
    @(posedge clk);
    #1;
    check("after retrigger done", 32'(done), 32'd0);
    check("after retrigger busy", 32'(busy), 32'd0);

    // Reset during SHIFT aborts the operation
    a     = 8'h77;
    b     = 8'h12;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int e = 0; e < 3 * W; e++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("no done after abort", 32'(done_seen), 32'd0);

    // WIDTH=1 instance: full truth table, two-cycle latency
    for (int i = 0; i < 8; i++) begin
      r1     = 2'(i);
      a1     = 1'((i >> 2) & 1);
      b1     = 1'((i >> 1) & 1);
      bin1   = 1'(i & 1);
      r1     = 2'({1'b0, a1} - {1'b0, b1} - {1'b0, bin1});
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check($sformatf("w1 %0d busy", i), 32'(busy1), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("w1 %0d done", i), 32'(done1), 32'd1);
      check($sformatf("w1 %0d diff", i), 32'(diff1), 32'(r1[0]));
      check($sformatf("w1 %0d bout", i), 32'(bout1), 32'(r1[1]));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
